// File: rtl/seq_multiplier.sv
// Unsigned shift-add sequential multiplier: a*b over WIDTH cycles after an
// accepted start rise, result held with done until the next accepted start.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic                 start_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     mreg_q, mreg_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 accept;
  logic [2*WIDTH-1:0]   acc_sum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      mreg_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      mreg_q    <= mreg_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    mreg_d    = mreg_q;
    count_d   = count_q;
    // start_q tracks in every state, so edges seen during CALC are consumed, not queued
    accept    = start & ~start_q & (state_q != CALC);
    acc_sum   = acc_q + (mreg_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          mcand_d = {{WIDTH{1'b0}}, a};
          mreg_d  = b;
          acc_d   = '0;
          count_d = CW'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mreg_d  = mreg_q >> 1;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          product_d = acc_sum;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=8 scenarios plus an exhaustive
// WIDTH=4 sweep, all expected products computed in the bench.
module tb_seq_multiplier;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [7:0]  a, b;
  logic [15:0] product;
  logic        done, busy;

  logic        start4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;
  logic        done4, busy4;

  int n_tests;
  int n_fail;

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .resetn(resetn), .start(start), .a(a), .b(b),
    .product(product), .done(done), .busy(busy)
  );

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .start(start4), .a(a4), .b(b4),
    .product(product4), .done(done4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation with a single-cycle start pulse; checks latency,
  // product hold during CALC and the busy/done exclusivity.
  task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] exp);
    int          cyc;
    logic [15:0] prev;
    prev = product;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_done_e0"}, 32'(done), 32'd0);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      check({tag, "_excl"}, 32'(busy & done), 32'd0);
      if (!done) check({tag, "_hold"}, 32'(product), 32'(prev));
    end
    check({tag, "_lat"}, 32'(cyc), 32'd8);
    check({tag, "_prod"}, 32'(product), 32'(exp));
  endtask

  task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] exp);
    int cyc;
    @(negedge clk);
    a4 = av; b4 = bv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy4 & done4) check("w4_excl", 32'(busy4 & done4), 32'd0);
    end
    check("w4_lat", 32'(cyc), 32'd4);
    check("w4_prod", 32'(product4), 32'(exp));
  endtask

  initial begin
    int   rises;
    logic done_prev;
    logic [7:0] ra, rb;

    n_tests = 0;
    n_fail  = 0;
    resetn = 1'b0; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;

    repeat (3) @(negedge clk);
    check("rst_product", 32'(product), 32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_product4", 32'(product4), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    run_op8("m13x11", 8'd13, 8'd11, 16'h008F);
    run_op8("m255x255", 8'd255, 8'd255, 16'hFE01);
    run_op8("m0x200", 8'd0, 8'd200, 16'd0);
    run_op8("m200x1", 8'd200, 8'd1, 16'd200);

    // start held high for 20 cycles: exactly one operation
    @(negedge clk);
    a = 8'd7; b = 8'd6; start = 1'b1;
    rises = 0; done_prev = done;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done && !done_prev) rises++;
      done_prev = done;
    end
    check("held_rises", 32'(rises), 32'd1);
    check("held_prod",  32'(product), 32'd42);
    check("held_done",  32'(done), 32'd1);
    start = 1'b0;
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("relaunch_done_drop", 32'(done), 32'd0);
    check("relaunch_busy",      32'(busy), 32'd1);
    repeat (8) @(negedge clk);
    check("relaunch_done", 32'(done), 32'd1);
    check("relaunch_prod", 32'(product), 32'd15);

    // mid-CALC operand change and start pulse are ignored
    @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin a = 8'd1; b = 8'd1; start = 1'b1; end
      if (i == 4) start = 1'b0;
    end
    check("mid_done", 32'(done), 32'd1);
    check("mid_prod", 32'(product), 32'd81);
    repeat (4) @(negedge clk);
    check("mid_no_relaunch_busy", 32'(busy), 32'd0);
    check("mid_no_relaunch_done", 32'(done), 32'd1);
    check("mid_prod_hold", 32'(product), 32'd81);

    // reset asserted during CALC cycle 3
    @(negedge clk);
    a = 8'd50; b = 8'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_done",    32'(done),    32'd0);
    check("midrst_busy",    32'(busy),    32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op8("m100x3", 8'd100, 8'd3, 16'd300);

    // start already high when reset releases is accepted on the first edge
    @(negedge clk);
    resetn = 1'b0; start = 1'b1; a = 8'd2; b = 8'd3;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("relstart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("relstart_done", 32'(done), 32'd1);
    check("relstart_prod", 32'(product), 32'd6);

    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      run_op8("rand8", ra, rb, 16'(ra) * 16'(rb));
    end

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        run_op4(4'(ia), 4'(ib), 8'(ia * ib));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
